// File: rtl/pulse_stretch_pkg.sv
//------------------------------------------------------------------------------
// Module : pulse_stretch_pkg
// Brief  : Shared state encodings, default lengths and helpers for pulse_stretch.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package pulse_stretch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam int DEF_ON_CYCLES  = 4;
  localparam int DEF_GAP_CYCLES = 2;
  localparam int DEF_PEND_W     = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pulse_stretch_cycle_timer.sv
//------------------------------------------------------------------------------
// Module : cycle_timer
// Brief  : Loadable down-counter that stops at zero; zero_o flags the final cycle.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cycle_timer #(
  parameter int W = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/pulse_stretch.sv
//------------------------------------------------------------------------------
// Module : pulse_stretch
// Brief  : Stretches single-cycle events into fixed-length LED flashes, queueing
//          events that arrive mid-flash. Optional sticky overflow flag when
//          PULSE_STRETCH_OVF_EN is defined.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pulse_stretch
  import pulse_stretch_pkg::*;
#(
  parameter int ON_CYCLES  = DEF_ON_CYCLES,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int PEND_W     = DEF_PEND_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              pulse_i,
  output logic              led_o,
  output logic              busy_o,
  output logic [PEND_W-1:0] pending_o
`ifdef PULSE_STRETCH_OVF_EN
  ,
  output logic              ovf_o
`endif
);

  localparam int TW = $clog2(max_int(ON_CYCLES, GAP_CYCLES) + 1);
  localparam logic [TW-1:0]     ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0]     GAP_LOAD = TW'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_e            state_q;
  logic              led_q;
  logic [PEND_W-1:0] pending_q;
  logic              t_load;
  logic [TW-1:0]     t_load_val;
  logic              t_zero;
  logic              pend_full;
  logic              gap_restart;

  assign pend_full   = (pending_q == PEND_MAX);
  assign gap_restart = t_zero && ((pending_q != '0) || pulse_i);

  always_comb begin
    t_load     = 1'b0;
    t_load_val = ON_LOAD;
    case (state_q)
      ST_IDLE: t_load = pulse_i;
      ST_ON: begin
        t_load     = t_zero;
        t_load_val = GAP_LOAD;
      end
      ST_GAP:  t_load = gap_restart;
      default: t_load = 1'b0;
    endcase
  end

  cycle_timer #(
    .W (TW)
  ) u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (t_load),
    .load_val_i (t_load_val),
    .zero_o     (t_zero)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      led_q     <= 1'b0;
      pending_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pulse_i) begin
            state_q <= ST_ON;
            led_q   <= 1'b1;
          end
        end
        ST_ON: begin
          if (t_zero) begin
            state_q <= ST_GAP;
            led_q   <= 1'b0;
          end
          if (pulse_i && !pend_full) begin
            pending_q <= pending_q + 1'b1;
          end
        end
        ST_GAP: begin
          if (t_zero) begin
            if (gap_restart) begin
              state_q <= ST_ON;
              led_q   <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
            end
            // A fresh event on the final gap cycle either starts the flash
            // itself or cancels the replay decrement.
            if (!pulse_i && (pending_q != '0)) begin
              pending_q <= pending_q - 1'b1;
            end
          end else if (pulse_i && !pend_full) begin
            pending_q <= pending_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          led_q   <= 1'b0;
        end
      endcase
    end
  end

`ifdef PULSE_STRETCH_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovf_q <= 1'b0;
    end else if (pulse_i && pend_full &&
                 ((state_q == ST_ON) || ((state_q == ST_GAP) && !t_zero))) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf_o = ovf_q;
`endif

  assign led_o     = led_q;
  assign busy_o    = (state_q != ST_IDLE);
  assign pending_o = pending_q;

endmodule

`default_nettype wire

// File: tb/tb_pulse_stretch.sv
//------------------------------------------------------------------------------
// Module : tb_pulse_stretch
// Brief  : Directed self-checking bench for pulse_stretch (ON=4, GAP=2, PEND_W=2).
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_pulse_stretch;

  logic       clk_i   = 1'b0;
  logic       rst_i   = 1'b0;
  logic       pulse_i = 1'b0;
  logic       led_o;
  logic       busy_o;
  logic [1:0] pending_o;
`ifdef PULSE_STRETCH_OVF_EN
  logic       ovf_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  pulse_stretch #(
    .ON_CYCLES  (4),
    .GAP_CYCLES (2),
    .PEND_W     (2)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .pulse_i   (pulse_i),
    .led_o     (led_o),
    .busy_o    (busy_o),
    .pending_o (pending_o)
`ifdef PULSE_STRETCH_OVF_EN
    ,
    .ovf_o     (ovf_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input int cyc, input int obs, input int exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic bit inr(input int c, input int a, input int b);
    return (c >= a) && (c <= b);
  endfunction

  task automatic do_reset();
    rst_i   = 1'b1;
    pulse_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  // Cycle c is the interval after the c-th edge following reset release;
  // a pulse driven in cycle c is sampled on the edge that ends it.
  task automatic run_test(input int id, input bit [63:0] pmask, input int ncyc);
    int  e_led, e_busy, e_pend;
    bit  four;
    do_reset();
    for (int c = 0; c < ncyc; c++) begin
      pulse_i = pmask[c];
      four    = (id == 3) || (id == 4);
      e_pend  = 0;
      if (id == 2) begin
        e_led  = int'(inr(c, 11, 14));
        e_busy = int'(inr(c, 11, 16));
      end else if (four) begin
        e_led  = int'(inr(c, 11, 14) || inr(c, 17, 20) || inr(c, 23, 26) || inr(c, 29, 32));
        e_busy = int'(inr(c, 11, 34));
        if (id == 3) begin
          if (c == 13) e_pend = 1;
          else if (c == 14) e_pend = 2;
        end else begin
          if (c == 12) e_pend = 1;
          else if (c == 13) e_pend = 2;
          else if (c == 14) e_pend = 3;
        end
        if (inr(c, 15, 16)) e_pend = 3;
        else if (inr(c, 17, 22)) e_pend = 2;
        else if (inr(c, 23, 28)) e_pend = 1;
      end else begin
        e_led  = int'(inr(c, 11, 14) || inr(c, 17, 20));
        e_busy = int'(inr(c, 11, 22));
      end
      chk($sformatf("t%0d_led", id), c, int'(led_o), e_led);
      chk($sformatf("t%0d_busy", id), c, int'(busy_o), e_busy);
      chk($sformatf("t%0d_pend", id), c, int'(pending_o), e_pend);
`ifdef PULSE_STRETCH_OVF_EN
      chk($sformatf("t%0d_ovf", id), c, int'(ovf_o), int'((id == 4) && (c >= 15)));
`endif
      @(posedge clk_i);
      #1;
    end
    pulse_i = 1'b0;
  endtask

  initial begin
    bit [63:0] m;

    // Test 1: asynchronous reset with no clock edge
    #1 rst_i = 1'b1;
    #1;
    chk("t1_led", 0, int'(led_o), 0);
    chk("t1_busy", 0, int'(busy_o), 0);
    chk("t1_pend", 0, int'(pending_o), 0);
`ifdef PULSE_STRETCH_OVF_EN
    chk("t1_ovf", 0, int'(ovf_o), 0);
`endif

    m = '0; m[10] = 1'b1;
    run_test(2, m, 20);

    m = '0; m[10] = 1'b1; m[12] = 1'b1; m[13] = 1'b1; m[14] = 1'b1;
    run_test(3, m, 40);

    m = '0; m[10] = 1'b1; m[11] = 1'b1; m[12] = 1'b1; m[13] = 1'b1; m[14] = 1'b1;
    run_test(4, m, 40);

    m = '0; m[10] = 1'b1; m[16] = 1'b1;
    run_test(5, m, 28);

    // Test 6: reset mid-flash with one event queued
    do_reset();
    for (int c = 0; c < 13; c++) begin
      pulse_i = (c == 10) || (c == 12);
      @(posedge clk_i);
      #1;
    end
    pulse_i = 1'b0;
    chk("t6_pre_led", 13, int'(led_o), 1);
    chk("t6_pre_pend", 13, int'(pending_o), 1);
    #2 rst_i = 1'b1;
    #1;
    chk("t6_rst_led", 13, int'(led_o), 0);
    chk("t6_rst_pend", 13, int'(pending_o), 0);
    chk("t6_rst_busy", 13, int'(busy_o), 0);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    for (int c = 0; c < 16; c++) begin
      chk("t6_post_led", c, int'(led_o), 0);
      chk("t6_post_busy", c, int'(busy_o), 0);
      @(posedge clk_i);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
